decoder_5to32: RTL and testbench

DECODER_5TO32 -- requirements
Module: decoder_5to32

---
 rtl/decoder_5to32.sv | 80 ++++++++
 tb/tb_decoder_5to32.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder: a combinational decode plus a registered capture path
// with change detection. Define DECODER_5TO32_ERRCHK_EN to add the sticky err_q checker.
module decoder_5to32 #(
  parameter bit HOLD_ON_DISABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  S,
  input  logic        en,
  output logic [31:0] m,
  output logic [31:0] m_q,
  output logic [4:0]  idx_q,
  output logic        valid_q,
  output logic        chg_q
`ifdef DECODER_5TO32_ERRCHK_EN
  ,
  output logic        err_q
`endif
);

  logic [31:0] w_m;
  logic        w_chg;

  logic [31:0] r_m_q;
  logic [4:0]  r_idx;
  logic        r_valid;
  logic        r_chg;

  // One comparator per output line, so m has no path through clk, rst or en.
  for (genvar i = 0; i < 32; i++) begin : g_dec
    assign w_m[i] = (S == 5'(i));
  end

  // A capture counts as a change when nothing was held yet, so the first capture
  // after reset pulses even for S=0.
  assign w_chg = !r_valid || (S != r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_q   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_chg   <= 1'b0;
    end else if (en) begin
      r_m_q   <= w_m;
      r_idx   <= S;
      r_valid <= 1'b1;
      r_chg   <= w_chg;
    end else begin
      r_chg <= 1'b0;
      if (!HOLD_ON_DISABLE) begin
        r_m_q   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign m       = w_m;
  assign m_q     = r_m_q;
  assign idx_q   = r_idx;
  assign valid_q = r_valid;
  assign chg_q   = r_chg;

`ifdef DECODER_5TO32_ERRCHK_EN
  logic w_onehot;
  logic w_bad;
  logic r_err;

  assign w_onehot = (r_m_q != '0) && ((r_m_q & (r_m_q - 32'd1)) == '0);
  assign w_bad    = r_valid ? !w_onehot : (r_m_q != '0);

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | w_bad;
  end

  assign err_q = r_err;
`endif

endmodule

// File: tb/tb_decoder_5to32.sv
// Scoreboard bench for decoder_5to32: runs a hold-on-disable and a clear-on-disable
// instance side by side from directed vectors with hand-computed expectations.
module tb_decoder_5to32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [4:0]  S   = '0;
  logic [31:0] m_h, m_c, mq_h, mq_c;
  logic [4:0]  idx_h, idx_c;
  logic        v_h, v_c, c_h, c_c;
`ifdef DECODER_5TO32_ERRCHK_EN
  logic        err_h, err_c;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  decoder_5to32 #(.HOLD_ON_DISABLE(1'b1)) u_hold (
    .clk(clk), .rst(rst), .S(S), .en(en), .m(m_h), .m_q(mq_h), .idx_q(idx_h),
    .valid_q(v_h), .chg_q(c_h)
`ifdef DECODER_5TO32_ERRCHK_EN
    , .err_q(err_h)
`endif
  );

  decoder_5to32 #(.HOLD_ON_DISABLE(1'b0)) u_clr (
    .clk(clk), .rst(rst), .S(S), .en(en), .m(m_c), .m_q(mq_c), .idx_q(idx_c),
    .valid_q(v_c), .chg_q(c_c)
`ifdef DECODER_5TO32_ERRCHK_EN
    , .err_q(err_c)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] mq_h;
    logic [4:0]  idx_h;
    logic        v_h, c_h;
    logic [31:0] mq_c;
    logic [4:0]  idx_c;
    logic        v_c, c_c;
  } exp_t;

  exp_t sb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: registered outputs are compared on the falling edge after capture.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".hold.m_q"},     mq_h,          e.mq_h);
        chk({e.name, ".hold.idx_q"},   32'(idx_h),    32'(e.idx_h));
        chk({e.name, ".hold.valid_q"}, 32'(v_h),      32'(e.v_h));
        chk({e.name, ".hold.chg_q"},   32'(c_h),      32'(e.c_h));
        chk({e.name, ".clr.m_q"},      mq_c,          e.mq_c);
        chk({e.name, ".clr.idx_q"},    32'(idx_c),    32'(e.idx_c));
        chk({e.name, ".clr.valid_q"},  32'(v_c),      32'(e.v_c));
        chk({e.name, ".clr.chg_q"},    32'(c_c),      32'(e.c_c));
      end
    end
  end

  // Apply one vector after a falling edge, check m combinationally, then queue
  // what both instances must show after the next rising edge.
  task automatic step(input string name, input logic r, input logic e, input logic [4:0] s,
                      input logic [31:0] m_exp,
                      input logic [31:0] xmq_h, input logic [4:0] xidx_h, input logic xv_h, input logic xc_h,
                      input logic [31:0] xmq_c, input logic [4:0] xidx_c, input logic xv_c, input logic xc_c);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; S = s;
    #1;
    chk({name, ".hold.m"}, m_h, m_exp);
    chk({name, ".clr.m"},  m_c, m_exp);
    x.name = name;
    x.mq_h = xmq_h; x.idx_h = xidx_h; x.v_h = xv_h; x.c_h = xc_h;
    x.mq_c = xmq_c; x.idx_c = xidx_c; x.v_c = xv_c; x.c_c = xc_c;
    sb.push_back(x);
  endtask

  initial begin
    // Reset for two cycles
    step("rst0", 1, 0, 5'd0,  32'h0000_0001, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);
    step("rst1", 1, 0, 5'd0,  32'h0000_0001, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);

    // Combinational sweep with the capture path idle
    for (int s = 0; s < 32; s++)
      step($sformatf("sweep%0d", s), 0, 0, 5'(s), 32'h1 << s,
           32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);
    step("sweep5",  0, 0, 5'd5,  32'h0000_0020, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);
    step("sweep20", 0, 0, 5'd20, 32'h0010_0000, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);

    // First capture after reset, S=0
    step("cap0",  0, 1, 5'd0, 32'h0000_0001, 32'h1, 5'd0, 1, 1, 32'h1, 5'd0, 1, 1);

    // Hold 7 for three cycles, then 8
    step("s7a",   0, 1, 5'd7, 32'h0000_0080, 32'h80, 5'd7, 1, 1, 32'h80, 5'd7, 1, 1);
    step("s7b",   0, 1, 5'd7, 32'h0000_0080, 32'h80, 5'd7, 1, 0, 32'h80, 5'd7, 1, 0);
    step("s7c",   0, 1, 5'd7, 32'h0000_0080, 32'h80, 5'd7, 1, 0, 32'h80, 5'd7, 1, 0);
    step("s8",    0, 1, 5'd8, 32'h0000_0100, 32'h100, 5'd8, 1, 1, 32'h100, 5'd8, 1, 1);

    // Capture 12, disable with S=3, then recapture 12
    step("s12",   0, 1, 5'd12, 32'h0000_1000, 32'h1000, 5'd12, 1, 1, 32'h1000, 5'd12, 1, 1);
    step("dis3a", 0, 0, 5'd3,  32'h0000_0008, 32'h1000, 5'd12, 1, 0, 32'h0,    5'd12, 0, 0);
    step("dis3b", 0, 0, 5'd3,  32'h0000_0008, 32'h1000, 5'd12, 1, 0, 32'h0,    5'd12, 0, 0);
    step("re12",  0, 1, 5'd12, 32'h0000_1000, 32'h1000, 5'd12, 1, 0, 32'h1000, 5'd12, 1, 1);

    // Wrap 31 -> 0, then repeat 0
    step("s31",   0, 1, 5'd31, 32'h8000_0000, 32'h8000_0000, 5'd31, 1, 1, 32'h8000_0000, 5'd31, 1, 1);
    step("wrap0", 0, 1, 5'd0,  32'h0000_0001, 32'h1, 5'd0, 1, 1, 32'h1, 5'd0, 1, 1);
    step("rep0",  0, 1, 5'd0,  32'h0000_0001, 32'h1, 5'd0, 1, 0, 32'h1, 5'd0, 1, 0);

    // Reset and enable on the same edge: reset wins, m unaffected
    step("rsten", 1, 1, 5'd31, 32'h8000_0000, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);
    step("post0", 0, 1, 5'd0,  32'h0000_0001, 32'h1, 5'd0, 1, 1, 32'h1, 5'd0, 1, 1);
    step("dis9",  0, 0, 5'd9,  32'h0000_0200, 32'h1, 5'd0, 1, 0, 32'h0, 5'd0, 0, 0);

`ifdef DECODER_5TO32_ERRCHK_EN
    // Random traffic: the checker must never fire
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("err_hold", 32'(err_h), 32'h0);
        chk("err_clr",  32'(err_c), 32'h0);
      end
      rst = ($urandom_range(0, 31) == 0);
      en  = $urandom_range(0, 1);
      S   = 5'($urandom_range(0, 31));
    end
`endif

    // Drain the scoreboard with a bounded wait
    begin
      int budget = 0;
      while (sb.size() > 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      #1;
      if (sb.size() > 0) begin
        n_total++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
